// File: rtl/outstream_check_pkg.sv
// Shared types and defaults for the stream source/sink pair at the node grid edge.
// Both ends of a stream agree on data width and maximum stream length through these defaults.
package outstream_check_pkg;

  localparam int OS_WIDTH = 11;
  localparam int OS_DEPTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FAIL_NONE     = 2'd0;
  localparam logic [1:0] FAIL_MISMATCH = 2'd1;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'd2;
  localparam logic [1:0] FAIL_OVERRUN  = 2'd3;

  // Index width for a stream of up to depth entries; never narrower than one bit.
  function automatic int idx_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/outstream_check_if.sv
// Write/wready handshake carrying one signed value per transfer from a node to the sink.
interface outstream_check_if #(
    parameter int WIDTH = outstream_check_pkg::OS_WIDTH
);

    logic                    write;
    logic signed [WIDTH-1:0] in;
    logic                    wready;

    modport master (output write, output in, input wready);
    modport slave  (input write, input in, output wready);

endinterface

// File: rtl/outstream_check_stream_timer.sv
// Idle-cycle counter: cleared on activity, counts while enabled, flags when it reaches LIMIT.
module outstream_check_stream_timer #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [TW-1:0] LIM = LIMIT[TW-1:0];

    logic [TW-1:0] cnt;

    // Holds at LIMIT so the counter cannot wrap back past the expiry point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (LIMIT != 0) && (cnt == LIM);

endmodule

// File: rtl/outstream_check.sv
// Output-edge sink: consumes a node's stream and checks it in order against a preloaded array,
// reporting pass, first mismatch, idle timeout or overrun on registered result outputs.
module outstream_check
    import outstream_check_pkg::*;
#(
    parameter int WIDTH   = OS_WIDTH,
    parameter int DEPTH   = OS_DEPTH,
    parameter int TIMEOUT = 1023,
    localparam int IW     = idx_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IW-1:0]           length,
    input  logic signed [WIDTH-1:0] expected [0:DEPTH-1],
    outstream_check_if.slave        bus,
    output logic [IW-1:0]           count,
    output logic                    done,
    output logic                    pass,
    output logic [1:0]              fail_code,
    output logic [IW-1:0]           mismatch_idx,
    output logic signed [WIDTH-1:0] got
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_PASS = ST_PASS;
    localparam logic [1:0] S_FAIL = ST_FAIL;

    logic [1:0]    state;
    logic [IW-1:0] len_r;
    logic          arm;
    logic          xfer;
    logic          hit;
    logic          last;
    logic          expire;

    // A start is only honoured outside RUN; a pending start also beats an overrun in PASS.
    assign arm  = start && (state != S_RUN);
    assign xfer = (state == S_RUN) && bus.write && bus.wready;
    assign hit  = (bus.in == expected[count]);
    assign last = (({1'b0, count} + 1'b1) == {1'b0, len_r});

    outstream_check_stream_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (arm || xfer),
        .en     ((state == S_RUN) && !xfer),
        .expire (expire)
    );

    // Length is captured at start so the overrun index reports the run that actually passed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            len_r        <= '0;
            bus.wready   <= 1'b0;
            count        <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_code    <= FAIL_NONE;
            mismatch_idx <= '0;
            got          <= '0;
        end else if (arm) begin
            len_r        <= length;
            bus.wready   <= 1'b0;
            count        <= '0;
            fail_code    <= FAIL_NONE;
            mismatch_idx <= '0;
            got          <= '0;
            if (length == '0) begin
                state <= S_PASS;
                done  <= 1'b1;
                pass  <= 1'b1;
            end else begin
                state <= S_RUN;
                done  <= 1'b0;
                pass  <= 1'b0;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (xfer) begin
                        // The cycle after every transfer is an ack slot with wready low.
                        bus.wready <= 1'b0;
                        if (!hit) begin
                            state        <= S_FAIL;
                            done         <= 1'b1;
                            fail_code    <= FAIL_MISMATCH;
                            mismatch_idx <= count;
                            got          <= bus.in;
                        end else begin
                            count <= count + 1'b1;
                            if (last) begin
                                state <= S_PASS;
                                done  <= 1'b1;
                                pass  <= 1'b1;
                            end
                        end
                    end else if (expire) begin
                        state        <= S_FAIL;
                        bus.wready   <= 1'b0;
                        done         <= 1'b1;
                        fail_code    <= FAIL_TIMEOUT;
                        mismatch_idx <= count;
                        got          <= '0;
                    end else begin
                        bus.wready <= (count < len_r);
                    end
                end
                S_PASS: begin
                    // wready is already low here, so the extra value is flagged but never consumed.
                    if (bus.write) begin
                        state        <= S_FAIL;
                        pass         <= 1'b0;
                        fail_code    <= FAIL_OVERRUN;
                        mismatch_idx <= len_r;
                        got          <= bus.in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_outstream_check.sv
// Directed bench for outstream_check: a flag-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_outstream_check;

    localparam int W   = 11;
    localparam int D   = 64;
    localparam int TMO = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [5:0]          length = '0;
    logic signed [W-1:0] exp_arr [0:D-1];
    logic [5:0]          count;
    logic                done;
    logic                pass;
    logic [1:0]          fail_code;
    logic [5:0]          mismatch_idx;
    logic signed [W-1:0] got;

    outstream_check_if #(.WIDTH(W)) ifc ();

    outstream_check #(
        .WIDTH   (W),
        .DEPTH   (D),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .length       (length),
        .expected     (exp_arr),
        .bus          (ifc),
        .count        (count),
        .done         (done),
        .pass         (pass),
        .fail_code    (fail_code),
        .mismatch_idx (mismatch_idx),
        .got          (got)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, want);
        end
    endtask

    // Reference model: run/done/pass flags and an idle-cycle tally, stepped on each edge.
    bit m_running = 0, m_done = 0, m_pass = 0, m_wready = 0;
    int m_code = 0, m_idx = 0, m_got = 0, m_count = 0, m_len = 0, m_idle = 0;

    task automatic m_fail(input int code, input int idx, input int val);
        m_running = 0; m_done = 1; m_pass = 0; m_wready = 0;
        m_code = code; m_idx = idx; m_got = val;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_running = 0; m_done = 0; m_pass = 0; m_wready = 0;
                m_code = 0; m_idx = 0; m_got = 0; m_count = 0; m_len = 0; m_idle = 0;
            end else if (start && !m_running) begin
                m_len = int'(length);
                m_count = 0; m_code = 0; m_idx = 0; m_got = 0; m_idle = 0; m_wready = 0;
                m_running = (length != 0);
                m_done = (length == 0);
                m_pass = (length == 0);
            end else if (m_running) begin
                if (ifc.write && m_wready) begin
                    m_idle = 0;
                    m_wready = 0;
                    if (ifc.in != exp_arr[m_count]) begin
                        m_fail(1, m_count, int'(ifc.in));
                    end else begin
                        m_count++;
                        if (m_count == m_len) begin
                            m_running = 0; m_done = 1; m_pass = 1;
                        end
                    end
                end else if (m_idle == TMO) begin
                    m_fail(2, m_count, 0);
                end else begin
                    m_idle++;
                    m_wready = 1;
                end
            end else if (m_pass && ifc.write) begin
                m_fail(3, m_len, int'(ifc.in));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("wready", int'(ifc.wready), int'(m_wready));
            chk("count", int'(count), m_count);
            chk("done", int'(done), int'(m_done));
            chk("pass", int'(pass), int'(m_pass));
            chk("fail_code", int'(fail_code), m_code);
            chk("mismatch_idx", int'(mismatch_idx), m_idx);
            chk("got", int'(got), m_got);
        end
    end

    // Stimulus helpers run at negedges.
    task automatic kick(input int len);
        start = 1'b1;
        length = 6'(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int v);
        bit took;
        bit ok;
        ok = 0;
        ifc.write = 1'b1;
        ifc.in = W'(v);
        for (int i = 0; i < 20; i++) begin
            took = ifc.wready;
            @(negedge clk);
            if (took) begin
                ok = 1;
                break;
            end
        end
        ifc.write = 1'b0;
        chk("send_acked", int'(ok), 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int n;
        ifc.write = 1'b0;
        ifc.in = '0;
        for (int i = 0; i < D; i++) exp_arr[i] = '0;
        idle(2);
        chk("rst_done", int'(done), 0);
        chk("rst_wready", int'(ifc.wready), 0);
        rst = 1'b0;
        idle(1);

        // Happy path
        exp_arr[0] = 5; exp_arr[1] = -7; exp_arr[2] = 999;
        kick(3);
        send(5);
        chk("hp_ack_slot0", int'(ifc.wready), 0);
        send(-7);
        chk("hp_ack_slot1", int'(ifc.wready), 0);
        send(999);
        chk("hp_count", int'(count), 3);
        chk("hp_done", int'(done), 1);
        chk("hp_pass", int'(pass), 1);
        chk("hp_code", int'(fail_code), 0);
        idle(2);

        // Mismatch on third value
        exp_arr[0] = 1; exp_arr[1] = 2; exp_arr[2] = 3; exp_arr[3] = 4;
        kick(4);
        send(1);
        send(2);
        send(9);
        chk("mm_code", int'(fail_code), 1);
        chk("mm_idx", int'(mismatch_idx), 2);
        chk("mm_got", int'(got), 9);
        chk("mm_count", int'(count), 2);
        idle(3);
        chk("mm_wready_low", int'(ifc.wready), 0);
        chk("mm_pass", int'(pass), 0);

        // Timeout after one transfer
        exp_arr[0] = 11; exp_arr[1] = 12;
        kick(2);
        send(11);
        n = 1;
        while (fail_code != 2'd2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", n, TMO + 2);
        chk("tmo_idx", int'(mismatch_idx), 1);
        chk("tmo_got", int'(got), 0);
        chk("tmo_done", int'(done), 1);

        // Overrun in PASS, then restart
        exp_arr[0] = -1024;
        kick(1);
        send(-1024);
        chk("ov_pass_first", int'(pass), 1);
        ifc.write = 1'b1;
        ifc.in = W'(123);
        @(negedge clk);
        ifc.write = 1'b0;
        chk("ov_code", int'(fail_code), 3);
        chk("ov_idx", int'(mismatch_idx), 1);
        chk("ov_got", int'(got), 123);
        chk("ov_pass", int'(pass), 0);
        kick(1);
        chk("rs_done", int'(done), 0);
        chk("rs_code", int'(fail_code), 0);
        chk("rs_got", int'(got), 0);
        send(-1024);
        chk("rs_pass", int'(pass), 1);

        // Zero-length run
        kick(0);
        chk("z_done", int'(done), 1);
        chk("z_pass", int'(pass), 1);
        idle(3);
        chk("z_wready", int'(ifc.wready), 0);

        // Reset mid-run, then a clean five-value run
        exp_arr[0] = 10; exp_arr[1] = 20; exp_arr[2] = 30; exp_arr[3] = 40; exp_arr[4] = 50;
        kick(5);
        send(10);
        send(20);
        #2 rst = 1'b1;
        #1;
        chk("mr_count", int'(count), 0);
        chk("mr_wready", int'(ifc.wready), 0);
        chk("mr_done", int'(done), 0);
        chk("mr_code", int'(fail_code), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        kick(5);
        for (int i = 0; i < 5; i++) send(10 * (i + 1));
        chk("fr_count", int'(count), 5);
        chk("fr_pass", int'(pass), 1);

        // Start coinciding with an overrun attempt in PASS: start wins
        exp_arr[0] = 3;
        ifc.write = 1'b1;
        ifc.in = W'(3);
        kick(1);
        ifc.write = 1'b0;
        chk("sw_done", int'(done), 0);
        chk("sw_code", int'(fail_code), 0);
        send(3);
        chk("sw_pass", int'(pass), 1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
